// File: rtl/esc_pwm_engine.sv
// N-channel ESC PWM generator: arming sequence, double-buffered rates, high-time clamp.
// Optional macro SLEW_LIMIT_EN limits the per-period change of each channel's high time.
module esc_pwm_engine #(
  parameter int NUM_CH       = 4,
  parameter int RATE_WIDTH   = 8,
  parameter int SCALE_SHIFT  = 2,
  parameter int PERIOD_US    = 2500,
  parameter int MIN_HIGH_US  = 1000,
  parameter int MAX_HIGH_US  = 2000,
  parameter int ARM_PERIODS  = 4,
  parameter int SLEW_STEP_US = 50
) (
  input  logic                         us_clk,
  input  logic                         resetn,
  input  logic                         arm,
  input  logic [NUM_CH*RATE_WIDTH-1:0] rate_bus,
  input  logic                         rate_valid,
  output logic                         rate_ready,
  output logic [NUM_CH-1:0]            pwm,
  output logic                         period_start,
  output logic [1:0]                   state_out
);

  localparam int CNT_W   = $clog2(PERIOD_US);
  localparam int SUM_MAX = MIN_HIGH_US + ((2**RATE_WIDTH - 1) << SCALE_SHIFT);
  localparam int TOP     = (SUM_MAX > MAX_HIGH_US) ? SUM_MAX : MAX_HIGH_US;
  localparam int W_SUM   = $clog2(TOP + 1);
  localparam int W_STEP  = $clog2(SLEW_STEP_US + 1);
  localparam int W_A     = (W_SUM > CNT_W) ? W_SUM : CNT_W;
  localparam int HI_W    = (W_A > W_STEP) ? W_A : W_STEP;
  localparam int ARM_W   = $clog2(ARM_PERIODS + 1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'b00,
    ST_ARMING   = 2'b01,
    ST_RUN      = 2'b10
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [ARM_W-1:0]               arm_cnt_q, arm_cnt_d;
  logic [NUM_CH*RATE_WIDTH-1:0]   active_q, active_d;
  logic [NUM_CH*RATE_WIDTH-1:0]   shadow_q, shadow_d;
  logic                           pending_q, pending_d;
  logic [NUM_CH-1:0]              pwm_q, pwm_d;
  logic                           period_start_q;
  logic                           boundary, disarm, accept;
  logic [NUM_CH-1:0][HI_W-1:0]    hi_run;

  function automatic logic [HI_W-1:0] calc_hi(input logic [RATE_WIDTH-1:0] rate);
    logic [HI_W-1:0] sum;
    sum = HI_W'(MIN_HIGH_US) + (HI_W'(rate) << SCALE_SHIFT);
    if (sum > HI_W'(MAX_HIGH_US)) sum = HI_W'(MAX_HIGH_US);
    return sum;
  endfunction

  assign boundary = (cnt_q == CNT_W'(PERIOD_US - 1));
  assign disarm   = !arm && (state_q != ST_DISARMED);
  assign cnt_d    = boundary ? '0 : cnt_q + 1'b1;

  // valid/ready: a word transfers on any clock where rate_valid && rate_ready;
  // the source holds rate_bus stable while rate_valid is high and not yet accepted.
  assign rate_ready = !pending_q;
  assign accept     = rate_valid && rate_ready;

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    unique case (state_q)
      ST_DISARMED: begin
        if (arm && boundary) begin
          state_d   = ST_ARMING;
          arm_cnt_d = '0;
        end
      end
      ST_ARMING: begin
        if (!arm) begin
          state_d = ST_DISARMED;
        end else if (boundary) begin
          if (arm_cnt_q == ARM_W'(ARM_PERIODS - 1)) begin
            state_d   = ST_RUN;
            arm_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!arm) state_d = ST_DISARMED;
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (disarm) begin
      active_d  = '0;
      shadow_d  = '0;
      pending_d = 1'b0;
    end else begin
      if (boundary && pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
      if (accept) begin
        shadow_d  = rate_bus;
        pending_d = 1'b1;
      end
    end
  end

`ifdef SLEW_LIMIT_EN
  logic [NUM_CH-1:0][HI_W-1:0] applied_q, applied_d;

  function automatic logic [HI_W-1:0] slew(input logic [HI_W-1:0] cur,
                                           input logic [HI_W-1:0] tgt);
    logic [HI_W-1:0] res;
    res = tgt;
    if (tgt > cur) begin
      if (tgt - cur > HI_W'(SLEW_STEP_US)) res = cur + HI_W'(SLEW_STEP_US);
    end else if (cur - tgt > HI_W'(SLEW_STEP_US)) begin
      res = cur - HI_W'(SLEW_STEP_US);
    end
    return res;
  endfunction

  // Target uses the rates taking effect at this boundary, so a new rate starts slewing at once.
  always_comb begin
    applied_d = applied_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (disarm) begin
        applied_d[i] = HI_W'(MIN_HIGH_US);
      end else if (boundary && state_q == ST_RUN) begin
        applied_d[i] = slew(applied_q[i], calc_hi(active_d[i*RATE_WIDTH +: RATE_WIDTH]));
      end
    end
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) applied_q <= {NUM_CH{HI_W'(MIN_HIGH_US)}};
    else         applied_q <= applied_d;
  end

  assign hi_run = applied_q;
`else
  always_comb begin
    hi_run = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hi_run[i] = calc_hi(active_q[i*RATE_WIDTH +: RATE_WIDTH]);
    end
  end
`endif

  // Counter value 0 maps to the first registered high cycle, so cnt < hi gives exactly hi cycles.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!disarm) begin
        if (state_q == ST_ARMING)   pwm_d[i] = HI_W'(cnt_q) < HI_W'(MIN_HIGH_US);
        else if (state_q == ST_RUN) pwm_d[i] = HI_W'(cnt_q) < hi_run[i];
      end
    end
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_DISARMED;
      cnt_q          <= '0;
      arm_cnt_q      <= '0;
      active_q       <= '0;
      shadow_q       <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      arm_cnt_q      <= arm_cnt_d;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      period_start_q <= (cnt_q == '0);
    end
  end

  assign pwm          = pwm_q;
  assign period_start = period_start_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_esc_pwm_engine.sv
// Directed bench for esc_pwm_engine: reset, arming, rate updates, back-to-back writes, disarm, slew.
`timescale 1ns/1ps
module tb_esc_pwm_engine;

  localparam int NUM_CH = 4;
  localparam int PERIOD = 2500;

  logic              us_clk = 1'b0;
  logic              resetn;
  logic              arm;
  logic [31:0]       rate_bus;
  logic              rate_valid;
  logic              rate_ready;
  logic [NUM_CH-1:0] pwm;
  logic              period_start;
  logic [1:0]        state_out;

  int n_cmp  = 0;
  int n_fail = 0;

  int       meas_w[NUM_CH];
  int       exp_w[NUM_CH];
  int       meas_ps;
  bit       meas_ok;
  logic [1:0] meas_state;
  logic     meas_rdy;

  esc_pwm_engine #(
    .NUM_CH(4), .RATE_WIDTH(8), .SCALE_SHIFT(2), .PERIOD_US(2500),
    .MIN_HIGH_US(1000), .MAX_HIGH_US(2000), .ARM_PERIODS(4), .SLEW_STEP_US(50)
  ) dut (
    .us_clk(us_clk), .resetn(resetn), .arm(arm), .rate_bus(rate_bus),
    .rate_valid(rate_valid), .rate_ready(rate_ready), .pwm(pwm),
    .period_start(period_start), .state_out(state_out)
  );

  always #5 us_clk = ~us_clk;

  // Waits (bounded) for period_start, then samples one full period on negedges.
  // Optionally presents one write word for a single cycle at sample index wr_at.
  task automatic measure_period(input int wr_at, input logic [31:0] wr_data);
    meas_ok  = 1'b0;
    meas_ps  = 0;
    meas_rdy = 1'bx;
    for (int c = 0; c < NUM_CH; c++) meas_w[c] = 0;
    for (int t = 0; t < 3000 && period_start !== 1'b1; t++) @(negedge us_clk);
    if (period_start !== 1'b1) return;
    meas_ok    = 1'b1;
    meas_state = state_out;
    for (int k = 0; k < PERIOD; k++) begin
      if (k == wr_at) begin
        rate_bus   = wr_data;
        rate_valid = 1'b1;
      end
      if (k == wr_at + 1) begin
        rate_valid = 1'b0;
        meas_rdy   = rate_ready;
      end
      for (int c = 0; c < NUM_CH; c++) if (pwm[c] === 1'b1) meas_w[c]++;
      if (period_start === 1'b1) meas_ps++;
      @(negedge us_clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; arm = 1'b0; rate_valid = 1'b0; rate_bus = '0;
    repeat (3) @(negedge us_clk);
    n_cmp++; if (pwm !== 4'b0) begin n_fail++; $display("FAIL reset_pwm got %b want 0000", pwm); end
    n_cmp++; if (rate_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", rate_ready); end
    n_cmp++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL reset_ps got %b want 0", period_start); end
    n_cmp++; if (state_out !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", state_out); end
    resetn = 1'b1;
    measure_period(-1, '0);
    n_cmp++; if (meas_ok !== 1'b1) begin n_fail++; $display("FAIL reset_ps_timeout got %b want 1", meas_ok); end
    n_cmp++; if (meas_ps !== 1) begin n_fail++; $display("FAIL reset_ps_count got %0d want 1", meas_ps); end
    n_cmp++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL reset_ps_spacing got %b want 1", period_start); end
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++; if (meas_w[c] !== 0) begin n_fail++; $display("FAIL disarmed_w%0d got %0d want 0", c, meas_w[c]); end
    end
  endtask

  task automatic test_arming(input string tag);
    arm = 1'b1;
    repeat (2) @(negedge us_clk);
    for (int p = 0; p < 4; p++) begin
      measure_period(-1, '0);
      n_cmp++; if (meas_ok !== 1'b1) begin n_fail++; $display("FAIL %s_timeout p%0d got %b want 1", tag, p, meas_ok); end
      n_cmp++; if (meas_state !== 2'b01) begin n_fail++; $display("FAIL %s_state p%0d got %b want 01", tag, p, meas_state); end
      for (int c = 0; c < NUM_CH; c++) begin
        n_cmp++; if (meas_w[c] !== 1000) begin n_fail++; $display("FAIL %s_w%0d p%0d got %0d want 1000", tag, c, p, meas_w[c]); end
      end
    end
    n_cmp++; if (state_out !== 2'b10) begin n_fail++; $display("FAIL %s_run_state got %b want 10", tag, state_out); end
    measure_period(-1, '0);
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++; if (meas_w[c] !== 1000) begin n_fail++; $display("FAIL %s_run_w%0d got %0d want 1000", tag, c, meas_w[c]); end
    end
  endtask

  task automatic test_rate_update();
    measure_period(500, 32'h107D00FF);
    n_cmp++; if (meas_rdy !== 1'b0) begin n_fail++; $display("FAIL upd_ready_pending got %b want 0", meas_rdy); end
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++; if (meas_w[c] !== 1000) begin n_fail++; $display("FAIL upd_cur_w%0d got %0d want 1000", c, meas_w[c]); end
    end
    n_cmp++; if (rate_ready !== 1'b1) begin n_fail++; $display("FAIL upd_ready_after got %b want 1", rate_ready); end
    measure_period(-1, '0);
    exp_w = '{2000, 1000, 1500, 1064};
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++; if (meas_w[c] !== exp_w[c]) begin n_fail++; $display("FAIL upd_next_w%0d got %0d want %0d", c, meas_w[c], exp_w[c]); end
    end
  endtask

  task automatic test_back_to_back();
    int rdy_hi;
    logic rdy_end;
    rdy_hi  = 0;
    rdy_end = 1'bx;
    for (int c = 0; c < NUM_CH; c++) meas_w[c] = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (k == 100) begin rate_bus = 32'h19FA0032; rate_valid = 1'b1; end
      if (k == 101) rate_bus = 32'hC8017D64;
      if (k >= 101 && k <= PERIOD - 2 && rate_ready !== 1'b0) rdy_hi++;
      if (k == PERIOD - 1) rdy_end = rate_ready;
      for (int c = 0; c < NUM_CH; c++) if (pwm[c] === 1'b1) meas_w[c]++;
      @(negedge us_clk);
    end
    rate_valid = 1'b0;
    n_cmp++; if (rdy_hi !== 0) begin n_fail++; $display("FAIL b2b_ready_held got %0d high want 0", rdy_hi); end
    n_cmp++; if (rdy_end !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_boundary got %b want 1", rdy_end); end
    n_cmp++; if (rate_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_b_accepted got %b want 0", rate_ready); end
    exp_w = '{2000, 1000, 1500, 1064};
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++; if (meas_w[c] !== exp_w[c]) begin n_fail++; $display("FAIL b2b_k_w%0d got %0d want %0d", c, meas_w[c], exp_w[c]); end
    end
    measure_period(-1, '0);
    exp_w = '{1200, 1000, 2000, 1100};
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++; if (meas_w[c] !== exp_w[c]) begin n_fail++; $display("FAIL b2b_a_w%0d got %0d want %0d", c, meas_w[c], exp_w[c]); end
    end
    n_cmp++; if (rate_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_free got %b want 1", rate_ready); end
    measure_period(-1, '0);
    exp_w = '{1400, 1500, 1004, 1800};
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++; if (meas_w[c] !== exp_w[c]) begin n_fail++; $display("FAIL b2b_b_w%0d got %0d want %0d", c, meas_w[c], exp_w[c]); end
    end
  endtask

  task automatic test_disarm();
    for (int k = 0; k < 300; k++) begin
      if (k == 100) begin rate_bus = 32'hFFFFFFFF; rate_valid = 1'b1; end
      if (k == 101) rate_valid = 1'b0;
      @(negedge us_clk);
    end
    n_cmp++; if (pwm[0] !== 1'b1) begin n_fail++; $display("FAIL dis_mid_pulse got %b want 1", pwm[0]); end
    n_cmp++; if (rate_ready !== 1'b0) begin n_fail++; $display("FAIL dis_pending got %b want 0", rate_ready); end
    arm = 1'b0;
    @(negedge us_clk);
    n_cmp++; if (pwm !== 4'b0) begin n_fail++; $display("FAIL dis_pwm got %b want 0000", pwm); end
    n_cmp++; if (state_out !== 2'b00) begin n_fail++; $display("FAIL dis_state got %b want 00", state_out); end
    n_cmp++; if (rate_ready !== 1'b1) begin n_fail++; $display("FAIL dis_ready got %b want 1", rate_ready); end
    repeat (5) @(negedge us_clk);
    test_arming("rearm");
  endtask

`ifdef SLEW_LIMIT_EN
  task automatic test_slew();
    measure_period(100, 32'hFAFAFAFA);
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++; if (meas_w[c] !== 1000) begin n_fail++; $display("FAIL slew_w%0d n0 got %0d want 1000", c, meas_w[c]); end
    end
    for (int n = 1; n <= 20; n++) begin
      measure_period(-1, '0);
      for (int c = 0; c < NUM_CH; c++) begin
        n_cmp++; if (meas_w[c] !== 1000 + 50 * n) begin n_fail++; $display("FAIL slew_up_w%0d n%0d got %0d want %0d", c, n, meas_w[c], 1000 + 50 * n); end
      end
    end
    measure_period(100, 32'h00000000);
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++; if (meas_w[c] !== 2000) begin n_fail++; $display("FAIL slew_top_w%0d got %0d want 2000", c, meas_w[c]); end
    end
    for (int n = 1; n <= 2; n++) begin
      measure_period(-1, '0);
      for (int c = 0; c < NUM_CH; c++) begin
        n_cmp++; if (meas_w[c] !== 2000 - 50 * n) begin n_fail++; $display("FAIL slew_dn_w%0d n%0d got %0d want %0d", c, n, meas_w[c], 2000 - 50 * n); end
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    repeat (200) @(negedge us_clk);
    n_cmp++; if (pwm[0] !== 1'b1) begin n_fail++; $display("FAIL ares_pulse got %b want 1", pwm[0]); end
    resetn = 1'b0;
    arm    = 1'b0;
    #1;
    n_cmp++; if (pwm !== 4'b0) begin n_fail++; $display("FAIL ares_pwm got %b want 0000", pwm); end
    n_cmp++; if (state_out !== 2'b00) begin n_fail++; $display("FAIL ares_state got %b want 00", state_out); end
    repeat (2) @(negedge us_clk);
    resetn = 1'b1;
    #1;
    n_cmp++; if (rate_ready !== 1'b1) begin n_fail++; $display("FAIL ares_ready got %b want 1", rate_ready); end
    measure_period(-1, '0);
    n_cmp++; if (meas_ok !== 1'b1) begin n_fail++; $display("FAIL ares_ps_timeout got %b want 1", meas_ok); end
    n_cmp++; if (meas_ps !== 1) begin n_fail++; $display("FAIL ares_ps_count got %0d want 1", meas_ps); end
    n_cmp++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL ares_ps_spacing got %b want 1", period_start); end
  endtask

  initial begin
    test_reset();
    test_arming("arm");
`ifdef SLEW_LIMIT_EN
    test_slew();
`else
    test_rate_update();
    test_back_to_back();
    test_disarm();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
